// File: rtl/wb_sequencer.sv
// Register-file writeback sequencer: drives the single write port, splits two-destination
// results into back-to-back writes and holds the sticky processor halt state.
module wb_sequencer #(
    parameter int unsigned              DATA_W   = 16,
    parameter int unsigned              REG_AW   = 4,
    parameter logic [REG_AW-1:0]        R15_ADDR = 4'd15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wdst,
    input  logic              halt,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [DATA_W-1:0] res_a,
    input  logic [DATA_W-1:0] res_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              halted
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSecond   = 2'd1;
    localparam logic [1:0] StHaltPend = 2'd2;
    localparam logic [1:0] StHalted   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [REG_AW-1:0] sec_addr_q, sec_addr_d;
    logic [DATA_W-1:0] sec_data_q, sec_data_d;
    logic              we_d;
    logic [REG_AW-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              two_writes;

    assign in_ready   = (state_q == StIdle);
    assign two_writes = (wdst == 2'b01) || (wdst == 2'b10);

    always_comb begin
        state_d    = state_q;
        sec_addr_d = sec_addr_q;
        sec_data_d = sec_data_q;
        we_d       = 1'b0;
        waddr_d    = rf_waddr;
        wdata_d    = rf_wdata;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (wdst != 2'b11) begin
                        we_d    = 1'b1;
                        waddr_d = rd_addr;
                        wdata_d = res_a;
                    end
                    if (two_writes) begin
                        sec_addr_d = (wdst == 2'b01) ? rs_addr : R15_ADDR;
                        sec_data_d = res_b;
                        state_d    = halt ? StHaltPend : StSecond;
                    end else begin
                        state_d    = halt ? StHalted : StIdle;
                    end
                end
            end
            StSecond, StHaltPend: begin
                we_d    = 1'b1;
                waddr_d = sec_addr_q;
                wdata_d = sec_data_q;
                state_d = (state_q == StHaltPend) ? StHalted : StIdle;
            end
            default: state_d = StHalted;
        endcase
    end

    // halted tracks entry into StHalted so it rises with the halting instruction's last write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sec_addr_q <= '0;
            sec_data_q <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_addr_q <= sec_addr_d;
            sec_data_q <= sec_data_d;
            rf_we      <= we_d;
            rf_waddr   <= waddr_d;
            rf_wdata   <= wdata_d;
            halted     <= (state_d == StHalted);
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer; outputs are sampled 1 time unit after
// each rising edge, inputs are changed at the same point.
module tb_wb_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wdst;
    logic        halt;
    logic [3:0]  rd_addr;
    logic [3:0]  rs_addr;
    logic [15:0] res_a;
    logic [15:0] res_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        halted;

    int n_cmp;
    int n_bad;

    wb_sequencer #(
        .DATA_W   (16),
        .REG_AW   (4),
        .R15_ADDR (4'd15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wdst     (wdst),
        .halt     (halt),
        .rd_addr  (rd_addr),
        .rs_addr  (rs_addr),
        .res_a    (res_a),
        .res_b    (res_b),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the write port and status in one go.
    task automatic chk_out(input string tag, input logic we, input logic [3:0] a,
                           input logic [15:0] d, input logic rdy, input logic hlt);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
        chk({tag, ".wdata"}, 32'(rf_wdata), 32'(d));
        chk({tag, ".ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".halted"}, 32'(halted), 32'(hlt));
    endtask

    task automatic bundle(input logic [1:0] w, input logic h, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        wdst     = w;
        halt     = h;
        rd_addr  = rd;
        rs_addr  = rs;
        res_a    = a;
        res_b    = b;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        wdst     = 2'b00;
        halt     = 1'b0;
        rd_addr  = '0;
        rs_addr  = '0;
        res_a    = '0;
        res_b    = '0;

        #3;
        chk_out("reset", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_reset.ready", 32'(in_ready), 32'd1);

        // Three single writes back to back
        bundle(2'b00, 1'b0, 4'd1, 4'd0, 16'h0011, 16'h0000);
        tick();
        chk_out("single1", 1'b1, 4'd1, 16'h0011, 1'b1, 1'b0);
        bundle(2'b00, 1'b0, 4'd2, 4'd0, 16'h0022, 16'h0000);
        tick();
        chk_out("single2", 1'b1, 4'd2, 16'h0022, 1'b1, 1'b0);
        bundle(2'b00, 1'b0, 4'd3, 4'd0, 16'h0033, 16'h0000);
        tick();
        chk_out("single3", 1'b1, 4'd3, 16'h0033, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_out("single_idle", 1'b0, 4'd3, 16'h0033, 1'b1, 1'b0);

        // Swap followed by a held single-write bundle
        bundle(2'b01, 1'b0, 4'd4, 4'd5, 16'hAAAA, 16'h5555);
        tick();
        chk_out("swap_first", 1'b1, 4'd4, 16'hAAAA, 1'b0, 1'b0);
        bundle(2'b00, 1'b0, 4'd6, 4'd0, 16'h0066, 16'h0000);
        tick();
        chk_out("swap_second", 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0);
        tick();
        chk_out("swap_next", 1'b1, 4'd6, 16'h0066, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_out("swap_idle", 1'b0, 4'd6, 16'h0066, 1'b1, 1'b0);

        // MUL: second write to R15
        bundle(2'b10, 1'b0, 4'd2, 4'd0, 16'h1234, 16'h00FF);
        tick();
        chk_out("mul_first", 1'b1, 4'd2, 16'h1234, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_out("mul_second", 1'b1, 4'd15, 16'h00FF, 1'b1, 1'b0);
        tick();
        chk_out("mul_idle", 1'b0, 4'd15, 16'h00FF, 1'b1, 1'b0);

        // MUL with rd == R15: both writes, res_b last
        bundle(2'b10, 1'b0, 4'd15, 4'd0, 16'h1234, 16'h00FF);
        tick();
        chk_out("mul15_first", 1'b1, 4'd15, 16'h1234, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_out("mul15_second", 1'b1, 4'd15, 16'h00FF, 1'b1, 1'b0);

        // HALT with no write, then further bundles held valid
        bundle(2'b11, 1'b1, 4'd9, 4'd0, 16'h0099, 16'h0000);
        tick();
        chk_out("halt11", 1'b0, 4'd15, 16'h00FF, 1'b0, 1'b1);
        bundle(2'b00, 1'b0, 4'd10, 4'd0, 16'h00AA, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("halt11_hold", 1'b0, 4'd15, 16'h00FF, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_out("halt11_reset", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;

        // HALT on a swap: halted rises with the second write
        bundle(2'b01, 1'b1, 4'd1, 4'd2, 16'h0101, 16'h0202);
        tick();
        chk_out("halt01_first", 1'b1, 4'd1, 16'h0101, 1'b0, 1'b0);
        tick();
        chk_out("halt01_second", 1'b1, 4'd2, 16'h0202, 1'b0, 1'b1);
        tick();
        chk_out("halt01_hold", 1'b0, 4'd2, 16'h0202, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset during the SECOND cycle discards the pending write to r8
        bundle(2'b01, 1'b0, 4'd7, 4'd8, 16'h0707, 16'h0808);
        tick();
        chk_out("rst2_first", 1'b1, 4'd7, 16'h0707, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_out("rst2_async", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk_out("rst2_held", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("rst2_release", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        bundle(2'b00, 1'b0, 4'd3, 4'd0, 16'h3333, 16'h0000);
        tick();
        chk_out("rst2_new", 1'b1, 4'd3, 16'h3333, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
